mmio_uart_tx: RTL

- Memory-mapped UART transmitter on the CPU data bus, downstream of pipelined_cpu.
- Consumes CPU stores (data_addr/data_wdata/data_wenable), buffers bytes in a FIFO and serialises them 8N1 on a tx pin.
- Returns status on reads and drives a level interrupt toward the CPU irq input.
- Sits beside dual_word_ram behind the system address decoder.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/mmio_uart_tx_sync_fifo.sv | 73 +++++++
 rtl/mmio_uart_tx.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter.
// Holds the register offsets, the STATUS/CTRL bit positions and the
// transmit FSM state enum.
// Optional build macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  // Byte offsets of the word registers
  localparam logic [3:0] UART_TXDATA = 4'h0;
  localparam logic [3:0] UART_STATUS = 4'h4;
  localparam logic [3:0] UART_CTRL   = 4'h8;
  localparam logic [3:0] UART_DIV    = 4'hC;

  // STATUS bit positions
  localparam int STAT_FULL  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  // CTRL bit positions
  localparam int CTRL_IRQ_EN    = 0;
  localparam int CTRL_PARITY_EN = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;
`endif

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// sync_fifo: single-clock FIFO with combinational read data (show-ahead).
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (flushes the FIFO)
//   push, wdata  write one entry
//   pop, rdata   rdata is the head entry; pop consumes it
//   full, empty, count  occupancy
// The caller must not push when full unless it pops in the same cycle, and
// must not pop when empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // Depth is a power of two, so the pointers wrap on their own.
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == DEPTH[AW:0]);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter on the CPU data bus.
// CPU stores to TXDATA are queued in a FIFO and sent 8N1 (LSB first) on tx.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   sel               decoder select; bus inputs ignored when low
//   addr[3:0]         byte offset (bits [1:0] ignored)
//   wdata[31:0]       store data
//   wenable[3:0]      byte strobes; nonzero = write, zero = read
//   rdata[31:0]       registered read data (updates the edge after a read)
//   tx                serial output, idle high
//   irq               registered level interrupt: irq_en & empty & ~busy
// Registers: 0x0 TXDATA (W), 0x4 STATUS (R/W1C), 0x8 CTRL (R/W), 0xC DIVISOR.
// Optional build macro: UART_TX_PARITY_EN makes CTRL bit1 writable and adds
// an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx
  import uart_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wenable,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [3:0]    off;
  logic          wr_en, rd_en, push_req, push, pop;
  logic          fifo_full, fifo_empty, busy;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;

  tx_state_e     state_q, state_d;
  logic [15:0]   cnt_q, cnt_d, bit_load;
  logic [2:0]    bit_q, bit_d, bit_nxt;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          irq_q, irq_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic [15:0]   div_q, div_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          par_en;
  logic          unused_ok;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_frame_q, par_frame_d;  // parity choice frozen at frame start
  assign par_en = par_en_q;
`else
  assign par_en = 1'b0;
`endif

  assign unused_ok = ^{wdata[31:16], addr[1:0], fifo_count};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .wdata(wdata[7:0]),
    .pop  (pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign busy = (state_q != ST_IDLE);

  // Counter reload is sampled from DIVISOR only at bit boundaries, so a
  // DIVISOR write never shortens the bit in flight. Zero behaves as one.
  assign bit_load = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

  // Transmit FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    data_d  = data_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    bit_nxt = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
    par_frame_d = par_frame_q;
`endif
    case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        pop  = !fifo_empty;
      end
      ST_START: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
          tx_d    = data_q[0];
          cnt_d   = bit_load;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == 16'd0) begin
          cnt_d = bit_load;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            tx_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
            if (par_frame_q) begin
              state_d = ST_PARITY;
              tx_d    = ^data_q;
            end
`endif
          end else begin
            bit_d = bit_nxt;
            tx_d  = data_q[bit_nxt];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == 16'd0) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          cnt_d   = bit_load;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == 16'd0) begin
          // Chain straight into the next start bit when data is waiting.
          if (fifo_empty) begin
            state_d = ST_IDLE;
          end else begin
            pop = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (pop) begin
      data_d  = fifo_rdata;
      state_d = ST_START;
      tx_d    = 1'b0;
      cnt_d   = bit_load;
`ifdef UART_TX_PARITY_EN
      par_frame_d = par_en_q;
`endif
    end
  end

  // Bus decode, register writes and read mux
  always_comb begin
    off      = {addr[3:2], 2'b00};
    wr_en    = sel && (wenable != 4'b0000);
    rd_en    = sel && (wenable == 4'b0000);
    push_req = wr_en && (off == UART_TXDATA) && wenable[0];
    // A full FIFO still accepts when the FSM frees a slot this cycle.
    push     = push_req && (!fifo_full || pop);

    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    div_d    = div_q;
    rdata_d  = rdata_q;
`ifdef UART_TX_PARITY_EN
    par_en_d = par_en_q;
`endif

    if (wr_en && (off == UART_STATUS) && wenable[0] && wdata[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end
    if (wr_en && (off == UART_CTRL) && wenable[0]) begin
      irq_en_d = wdata[CTRL_IRQ_EN];
`ifdef UART_TX_PARITY_EN
      par_en_d = wdata[CTRL_PARITY_EN];
`endif
    end
    if (wr_en && (off == UART_DIV)) begin
      if (wenable[0]) div_d[7:0]  = wdata[7:0];
      if (wenable[1]) div_d[15:8] = wdata[15:8];
    end

    if (rd_en) begin
      case (off)
        UART_STATUS: rdata_d = {28'd0, ovf_q, busy, fifo_empty, fifo_full};
        UART_CTRL:   rdata_d = {30'd0, par_en, irq_en_q};
        UART_DIV:    rdata_d = {16'd0, div_q};
        default:     rdata_d = 32'd0;
      endcase
    end

    irq_d = irq_en_q && fifo_empty && !busy;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      div_q    <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
      par_en_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      div_q    <= div_d;
`ifdef UART_TX_PARITY_EN
      par_en_q <= par_en_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    data_q <= data_d;
`ifdef UART_TX_PARITY_EN
    par_frame_q <= par_frame_d;
`endif
  end

  assign rdata = rdata_q;
  assign tx    = tx_q;
  assign irq   = irq_q;

endmodule
